// File: rtl/xbar_arb_pkg.sv
// Shared types and constants for the per-slave crossbar round-robin arbiter.
package xbar_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        REQ  = 2'd1,
        RESP = 2'd2
    } arb_state_t;

    localparam logic CMD_RD = 1'b0;
    localparam logic CMD_WR = 1'b1;

endpackage

// File: rtl/xbar_rr_arbiter_rr_pick.sv
// Combinational round-robin priority encoder: finds the first requester
// strictly after the last-served index, wrapping around.
module rr_pick #(
    parameter  int REGS_NUM = 4,
    localparam int IDX_W    = $clog2(REGS_NUM)
) (
    input  logic [REGS_NUM-1:0] req,
    input  logic [IDX_W-1:0]    last,
    output logic                valid,
    output logic [IDX_W-1:0]    idx,
    output logic [REGS_NUM-1:0] onehot
);

    int j;

    always_comb begin
        // NOTE: every output gets a default first so no path leaves it unassigned (no latch).
        valid  = 1'b0;
        idx    = '0;
        onehot = '0;
        j      = 0;
        for (int i = 1; i <= REGS_NUM; i++) begin
            j = int'(last) + i;
            if (j >= REGS_NUM) begin
                j = j - REGS_NUM;
            end
            if (!valid && req[j]) begin
                valid = 1'b1;
                idx   = IDX_W'(j);
            end
        end
        onehot[idx] = valid;
    end

endmodule

// File: rtl/xbar_rr_arbiter.sv
// Per-slave round-robin arbiter: grants one host at a time, forwards req/cmd
// to the slave, returns the ack, and holds read grants until the host takes the data.
module xbar_rr_arbiter
    import xbar_arb_pkg::*;
#(
    parameter  int REGS_NUM = 4,
    parameter  int TMO_CYC  = 255,
    localparam int IDX_W    = $clog2(REGS_NUM)
) (
    input  logic                clk_i,
    input  logic                reset_i,
    input  logic [REGS_NUM-1:0] req_i,
    input  logic [REGS_NUM-1:0] cmd_i,
    input  logic [REGS_NUM-1:0] resp_i,
    output logic [REGS_NUM-1:0] ack_o,
    output logic                slv_req_o,
    output logic                slv_cmd_o,
    input  logic                slv_ack_i,
    output logic [REGS_NUM-1:0] gnt_o,
    output logic [IDX_W-1:0]    gnt_idx_o,
    output logic                busy_o,
    output logic                err_o
);

    localparam int CNT_W = $clog2(TMO_CYC + 1);

    arb_state_t          state;
    logic [CNT_W-1:0]    cnt;
    logic [IDX_W-1:0]    ptr;
    logic                timeout;

    logic                pick_valid;
    logic [IDX_W-1:0]    pick_idx;
    logic [REGS_NUM-1:0] pick_onehot;

    rr_pick #(
        .REGS_NUM (REGS_NUM)
    ) u_pick (
        .req    (req_i),
        .last   (ptr),
        .valid  (pick_valid),
        .idx    (pick_idx),
        .onehot (pick_onehot)
    );

    // The last REQ cycle is the one where cnt == TMO_CYC-1, so err_o rises
    // exactly TMO_CYC cycles after slv_req_o.
    assign timeout = (cnt == CNT_W'(TMO_CYC - 1));

    // The ack is forwarded combinationally so the host sees it in the slave's ack cycle.
    assign ack_o = (slv_ack_i && state == REQ) ? gnt_o : '0;

    always_ff @(posedge clk_i) begin
        // NOTE: sequential state uses non-blocking assignments only.
        if (reset_i) begin
            state     <= IDLE;
            cnt       <= '0;
            ptr       <= IDX_W'(REGS_NUM - 1);
            gnt_o     <= '0;
            gnt_idx_o <= '0;
            slv_req_o <= 1'b0;
            slv_cmd_o <= CMD_RD;
            busy_o    <= 1'b0;
            err_o     <= 1'b0;
        end else begin
            err_o <= 1'b0;
            unique case (state)
                IDLE: begin
                    if (pick_valid) begin
                        state     <= REQ;
                        gnt_o     <= pick_onehot;
                        gnt_idx_o <= pick_idx;
                        slv_req_o <= 1'b1;
                        slv_cmd_o <= cmd_i[pick_idx];
                        busy_o    <= 1'b1;
                        cnt       <= '0;
                    end
                end

                REQ: begin
                    if (slv_ack_i) begin
                        slv_req_o <= 1'b0;
                        cnt       <= '0;
                        if (slv_cmd_o == CMD_WR) begin
                            state     <= IDLE;
                            gnt_o     <= '0;
                            busy_o    <= 1'b0;
                            slv_cmd_o <= CMD_RD;
                            ptr       <= gnt_idx_o;
                        end else begin
                            state <= RESP;
                        end
                    end else if (timeout) begin
                        // Abort: the stalled host loses priority for the next round.
                        state     <= IDLE;
                        gnt_o     <= '0;
                        busy_o    <= 1'b0;
                        slv_req_o <= 1'b0;
                        slv_cmd_o <= CMD_RD;
                        cnt       <= '0;
                        err_o     <= 1'b1;
                        ptr       <= gnt_idx_o;
                    end else begin
                        cnt <= cnt + CNT_W'(1);
                    end
                end

                RESP: begin
                    if (resp_i[gnt_idx_o]) begin
                        state     <= IDLE;
                        gnt_o     <= '0;
                        busy_o    <= 1'b0;
                        slv_cmd_o <= CMD_RD;
                        ptr       <= gnt_idx_o;
                    end
                end

                default: begin
                    state     <= IDLE;
                    gnt_o     <= '0;
                    busy_o    <= 1'b0;
                    slv_req_o <= 1'b0;
                    cnt       <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_xbar_rr_arbiter.sv
// Self-checking bench for xbar_rr_arbiter: per-cycle vector table plus a
// scoreboarded round-robin rotation run.
module tb_xbar_rr_arbiter;
    import xbar_arb_pkg::*;

    localparam int N   = 4;
    localparam int TMO = 4;

    logic         clk_i = 1'b0;
    logic         reset_i;
    logic [N-1:0] req_i, cmd_i, resp_i, ack_o, gnt_o;
    logic         slv_req_o, slv_cmd_o, slv_ack_i, busy_o, err_o;
    logic [1:0]   gnt_idx_o;

    int n_checks = 0;
    int n_fail   = 0;

    xbar_rr_arbiter #(
        .REGS_NUM (N),
        .TMO_CYC  (TMO)
    ) dut (
        .clk_i     (clk_i),
        .reset_i   (reset_i),
        .req_i     (req_i),
        .cmd_i     (cmd_i),
        .resp_i    (resp_i),
        .ack_o     (ack_o),
        .slv_req_o (slv_req_o),
        .slv_cmd_o (slv_cmd_o),
        .slv_ack_i (slv_ack_i),
        .gnt_o     (gnt_o),
        .gnt_idx_o (gnt_idx_o),
        .busy_o    (busy_o),
        .err_o     (err_o)
    );

    always #5 clk_i = ~clk_i;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    // One row = inputs held for one clock; ack is checked in-cycle,
    // registered outputs just after the edge.
    typedef struct {
        string      name;
        logic       rst;
        logic [3:0] req, cmd, resp;
        logic       sack;
        logic [3:0] ack, gnt;
        logic       sreq, busy, err, chk_idx;
        logic [1:0] idx;
        logic       scmd;
    } vec_t;

    vec_t tbl[$];

    function automatic vec_t mk(string name, logic rst, logic [3:0] req, logic [3:0] cmd,
                                logic [3:0] resp, logic sack, logic [3:0] ack, logic [3:0] gnt,
                                logic sreq, logic busy, logic err, logic chk_idx,
                                logic [1:0] idx, logic scmd);
        vec_t v;
        v.name = name; v.rst = rst; v.req = req; v.cmd = cmd; v.resp = resp;
        v.sack = sack; v.ack = ack; v.gnt = gnt; v.sreq = sreq; v.busy = busy;
        v.err = err; v.chk_idx = chk_idx; v.idx = idx; v.scmd = scmd;
        return v;
    endfunction

    task automatic run_row(input vec_t v);
        reset_i   = v.rst;
        req_i     = v.req;
        cmd_i     = v.cmd;
        resp_i    = v.resp;
        slv_ack_i = v.sack;
        #1;
        check({v.name, ".ack"}, 32'(ack_o), 32'(v.ack));
        @(posedge clk_i);
        #1;
        check({v.name, ".gnt"},  32'(gnt_o),     32'(v.gnt));
        check({v.name, ".sreq"}, 32'(slv_req_o), 32'(v.sreq));
        check({v.name, ".busy"}, 32'(busy_o),    32'(v.busy));
        check({v.name, ".err"},  32'(err_o),     32'(v.err));
        if (v.chk_idx) check({v.name, ".idx"}, 32'(gnt_idx_o), 32'(v.idx));
        if (v.sreq)    check({v.name, ".scmd"}, 32'(slv_cmd_o), 32'(v.scmd));
    endtask

    int          exp_q[$];
    int          ack_cnt[N];
    logic        prev_sreq;
    logic        err_seen;
    logic [3:0]  exp_oh;

    initial begin
        reset_i = 1'b1; req_i = '0; cmd_i = '0; resp_i = '0; slv_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        #1;
        check("rst.gnt",  32'(gnt_o),     0);
        check("rst.idx",  32'(gnt_idx_o), 0);
        check("rst.sreq", 32'(slv_req_o), 0);
        check("rst.scmd", 32'(slv_cmd_o), 0);
        check("rst.busy", 32'(busy_o),    0);
        check("rst.err",  32'(err_o),     0);
        check("rst.ack",  32'(ack_o),     0);

        //            name           rst req      cmd      resp     sack ack      gnt      sreq busy err chk idx scmd
        // write from host 1, then a stray slave ack while idle
        tbl.push_back(mk("t1_req",   0, 4'b0010, 4'b0010, 4'b0000, 0, 4'b0000, 4'b0010, 1, 1, 0, 1, 2'd1, 1));
        tbl.push_back(mk("t1_ack",   0, 4'b0010, 4'b0010, 4'b0000, 1, 4'b0010, 4'b0000, 0, 0, 0, 0, 2'd0, 0));
        tbl.push_back(mk("t1_idle",  0, 4'b0000, 4'b0000, 4'b0000, 1, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd0, 0));
        // read from host 2: held in RESP, wrong resp bit and cmd change ignored
        tbl.push_back(mk("t3_req",   0, 4'b0100, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0100, 1, 1, 0, 1, 2'd2, 0));
        tbl.push_back(mk("t3_ack",   0, 4'b0100, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0100, 0, 1, 0, 1, 2'd2, 0));
        tbl.push_back(mk("t3_wresp", 0, 4'b0000, 4'b1111, 4'b0001, 1, 4'b0000, 4'b0100, 0, 1, 0, 1, 2'd2, 0));
        tbl.push_back(mk("t3_resp",  0, 4'b0000, 4'b0000, 4'b0100, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd0, 0));
        // timeout on host 0 with host 1 pending
        tbl.push_back(mk("t4_req",   0, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0001, 1, 1, 0, 1, 2'd0, 1));
        tbl.push_back(mk("t4_w1",    0, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0001, 1, 1, 0, 1, 2'd0, 1));
        tbl.push_back(mk("t4_w2",    0, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0001, 1, 1, 0, 1, 2'd0, 1));
        tbl.push_back(mk("t4_w3",    0, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0001, 1, 1, 0, 1, 2'd0, 1));
        tbl.push_back(mk("t4_tmo",   0, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 1, 0, 2'd0, 0));
        tbl.push_back(mk("t4_next",  0, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0010, 1, 1, 0, 1, 2'd1, 1));
        // ack lands in the timeout cycle: ack wins, no err
        tbl.push_back(mk("t5_w1",    0, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0010, 1, 1, 0, 1, 2'd1, 1));
        tbl.push_back(mk("t5_w2",    0, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0010, 1, 1, 0, 1, 2'd1, 1));
        tbl.push_back(mk("t5_w3",    0, 4'b0011, 4'b0011, 4'b0000, 0, 4'b0000, 4'b0010, 1, 1, 0, 1, 2'd1, 1));
        tbl.push_back(mk("t5_ack",   0, 4'b0011, 4'b0011, 4'b0000, 1, 4'b0010, 4'b0000, 0, 0, 0, 0, 2'd0, 0));
        tbl.push_back(mk("t5_idle",  0, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 0, 2'd0, 0));
        // reset during RESP, then host 0 must win over host 3
        tbl.push_back(mk("t6_req",   0, 4'b0100, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0100, 1, 1, 0, 1, 2'd2, 0));
        tbl.push_back(mk("t6_ack",   0, 4'b0100, 4'b0000, 4'b0000, 1, 4'b0100, 4'b0100, 0, 1, 0, 1, 2'd2, 0));
        tbl.push_back(mk("t6_rst",   1, 4'b0000, 4'b0000, 4'b0000, 0, 4'b0000, 4'b0000, 0, 0, 0, 1, 2'd0, 0));
        tbl.push_back(mk("t6_req2",  0, 4'b1001, 4'b1001, 4'b0000, 0, 4'b0000, 4'b0001, 1, 1, 0, 1, 2'd0, 1));
        tbl.push_back(mk("t6_ack2",  0, 4'b1001, 4'b1001, 4'b0000, 1, 4'b0001, 4'b0000, 0, 0, 0, 0, 2'd0, 0));

        for (int k = 0; k < tbl.size(); k++) begin
            run_row(tbl[k]);
        end

        // Rotation run from a fresh reset: all hosts writing, slave always acking.
        reset_i = 1'b1; req_i = '0; cmd_i = '0; resp_i = '0; slv_ack_i = 1'b0;
        @(posedge clk_i);
        #1;
        reset_i = 1'b0;
        req_i = 4'b1111; cmd_i = 4'b1111; slv_ack_i = 1'b1;
        for (int r = 0; r < 2; r++) begin
            for (int h = 0; h < N; h++) exp_q.push_back(h);
        end
        for (int h = 0; h < N; h++) ack_cnt[h] = 0;
        prev_sreq = 1'b0;
        err_seen  = 1'b0;
        for (int cyc = 0; cyc < 40 && exp_q.size() > 0; cyc++) begin
            @(posedge clk_i);
            #1;
            err_seen = err_seen | err_o;
            for (int h = 0; h < N; h++) if (ack_o[h]) ack_cnt[h]++;
            if (slv_req_o && !prev_sreq) begin
                int e;
                e = exp_q.pop_front();
                exp_oh = 4'b0001 << e;
                check("rr.idx", 32'(gnt_idx_o), 32'(e));
                check("rr.gnt", 32'(gnt_o),     32'(exp_oh));
                check("rr.ack", 32'(ack_o),     32'(exp_oh));
            end else if (!slv_req_o) begin
                check("rr.idle_ack", 32'(ack_o), 0);
            end
            prev_sreq = slv_req_o;
        end
        check("rr.budget", 32'(exp_q.size()), 0);
        for (int h = 0; h < N; h++) check($sformatf("rr.ack_cnt%0d", h), 32'(ack_cnt[h]), 2);
        check("rr.err", 32'(err_seen), 0);

        req_i = '0; cmd_i = '0; slv_ack_i = 1'b0;
        repeat (2) @(posedge clk_i);
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
